// File: rtl/vga_pkg.sv
// Shared types and default widths for the VGA frame-buffer path.
package vga_pkg;

  localparam int PIXEL_WIDTH = 12;
  localparam int RAM_WIDTH   = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fb_rd_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush. Push and pop in one cycle both land.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = pop_i && (r_count != '0);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_do_push = push_i && ((r_count != FULL_CNT) || w_do_pop);

  always_ff @(posedge clk_i) begin
    if (w_do_push && !flush_i) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign data_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;
  assign full_o  = (r_count == FULL_CNT);
  assign empty_o = (r_count == '0);

endmodule

// File: rtl/fb_reader.sv
// Streams one frame out of a read-first BRAM as pixels, prefetching words into a small FIFO.
// Handshake: a pixel moves on a cycle where pix_valid_o && pix_ready_i; valid never waits on ready.
module fb_reader #(
  parameter int RAM_WIDTH   = vga_pkg::RAM_WIDTH,
  parameter int PIXEL_WIDTH = vga_pkg::PIXEL_WIDTH,
  parameter int RAM_DEPTH   = 1024,
  parameter int FRAME_WORDS = 1024,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  logic                             start_i,
  output logic                             ram_en_o,
  output logic                             ram_we_o,
  output logic [$clog2(RAM_DEPTH-1)-1:0]   ram_addr_o,
  input  logic [RAM_WIDTH-1:0]             ram_dout_i,
  output logic                             pix_valid_o,
  input  logic                             pix_ready_i,
  output logic [PIXEL_WIDTH-1:0]           pix_data_o,
  output logic                             pix_last_o,
  output logic                             underrun_o,
  output vga_pkg::fb_rd_state_t            state_o
);

  import vga_pkg::fb_rd_state_t;
  import vga_pkg::ST_IDLE;
  import vga_pkg::ST_RUN;
  import vga_pkg::ST_DRAIN;

  localparam int PPW = RAM_WIDTH / PIXEL_WIDTH;
  localparam int AW  = $clog2(RAM_DEPTH - 1);
  localparam int IW  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [AW-1:0] LAST_WORD  = AW'(FRAME_WORDS - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(PPW - 1);
  localparam logic [CW-1:0] FIFO_LIMIT = CW'(FIFO_DEPTH);

  fb_rd_state_t   r_state;
  logic [AW-1:0]  r_addr;
  logic [AW-1:0]  r_rd_word;
  logic [IW-1:0]  r_idx;
  logic           r_inflight;
  logic           r_underrun;

  logic                 w_rd;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [CW-1:0]        w_count;
  logic [RAM_WIDTH-1:0] w_head;

  // Reserve a FIFO slot for every outstanding read so a return never overflows.
  assign w_rd = (r_state == ST_RUN) && !start_i && !w_fifo_full &&
                ((w_count + CW'(r_inflight)) < FIFO_LIMIT);

  assign w_push   = r_inflight;
  assign w_accept = !w_fifo_empty && pix_ready_i;
  assign w_pop    = w_accept && (r_idx == LAST_IDX);
  assign w_last   = !w_fifo_empty && (r_idx == LAST_IDX) && (r_rd_word == LAST_WORD);

  sync_fifo #(
    .WIDTH (RAM_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (start_i),
    .push_i  (w_push),
    .data_i  (ram_dout_i),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .count_o (w_count),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_rd_word  <= '0;
      r_idx      <= '0;
      r_inflight <= 1'b0;
      r_underrun <= 1'b0;
    end else if (start_i) begin
      // Restart from any state; the FIFO flush drops whatever read returns now.
      r_state    <= ST_RUN;
      r_addr     <= '0;
      r_rd_word  <= '0;
      r_idx      <= '0;
      r_inflight <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_inflight <= w_rd;
      if (w_rd && (r_addr != LAST_WORD)) r_addr <= r_addr + AW'(1);
      if (w_accept) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
      if (w_pop && (r_rd_word != LAST_WORD)) r_rd_word <= r_rd_word + AW'(1);
      if ((r_state == ST_RUN) && pix_ready_i && w_fifo_empty) r_underrun <= 1'b1;
      case (r_state)
        ST_RUN:   if (w_rd && (r_addr == LAST_WORD)) r_state <= ST_DRAIN;
        ST_DRAIN: if (w_accept && w_last) r_state <= ST_IDLE;
        default:  r_state <= r_state;
      endcase
    end
  end

  assign ram_en_o    = w_rd;
  assign ram_we_o    = 1'b0;
  assign ram_addr_o  = r_addr;
  assign pix_valid_o = !w_fifo_empty;
  assign pix_data_o  = w_fifo_empty ? '0 : w_head[int'(r_idx)*PIXEL_WIDTH +: PIXEL_WIDTH];
  assign pix_last_o  = w_last;
  assign underrun_o  = r_underrun;
  assign state_o     = r_state;

endmodule

// File: doc/fb_reader.md
FB_READER -- requirements
Module: fb_reader

Interface
REQ-001 Parameter RAM_WIDTH, default 24: BRAM word width in bits.
REQ-002 Parameter PIXEL_WIDTH, default 12: pixel width; RAM_WIDTH SHALL be an integer multiple of it, giving PPW = RAM_WIDTH/PIXEL_WIDTH pixels per word.
REQ-003 Parameter RAM_DEPTH, default 1024: BRAM entries; address width AW = $clog2(RAM_DEPTH-1).
REQ-004 Parameter FRAME_WORDS, default 1024: words per frame, 1..RAM_DEPTH.
REQ-005 Parameter FIFO_DEPTH, default 4: prefetch FIFO entries in words, a power of 2, at least 2.
REQ-006 Port clk_i, in, 1: single clock, which also clocks the BRAM.
REQ-007 Port rstn_i, in, 1: asynchronous, active-low reset.
REQ-008 Port start_i, in, 1: single-cycle pulse that begins a frame at word 0.
REQ-009 Port ram_en_o, out, 1: BRAM port enable, which also acts as the read strobe.
REQ-010 Port ram_we_o, out, 1: BRAM write enable, constant 0.
REQ-011 Port ram_addr_o, out, AW: BRAM read address.
REQ-012 Port ram_dout_i, in, RAM_WIDTH: BRAM read data, valid one cycle after the ram_en_o strobe.
REQ-013 Port pix_valid_o, out, 1: pixel available.
REQ-014 Port pix_ready_i, in, 1: consumer accepts the pixel.
REQ-015 Port pix_data_o, out, PIXEL_WIDTH: pixel value.
REQ-016 Port pix_last_o, out, 1: marks the final pixel of the frame; qualified by pix_valid_o.
REQ-017 Port underrun_o, out, 1: sticky flag, set when the consumer asked for a pixel and none was available.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-019 In any state, start_i SHALL do all of the following: flush the FIFO, drop any in-flight read return, clear underrun_o, reset the word address to 0 and the pixel index to 0, and move to RUN on the next cycle.
REQ-020 In RUN, the block SHALL assert ram_en_o with ram_addr_o = word address only while (FIFO count + in-flight reads) < FIFO_DEPTH; the word address SHALL then increment.
REQ-021 RUN SHALL move to DRAIN in the cycle after the read of word FRAME_WORDS-1 is issued; DRAIN SHALL issue no reads.
REQ-022 The word address SHALL never exceed FRAME_WORDS-1; the only way it returns to 0 is through start_i.
REQ-023 ram_dout_i SHALL be written into the FIFO exactly one cycle after a strobe, unless that read was dropped by start_i.
REQ-024 pix_valid_o SHALL equal "FIFO not empty".
REQ-025 pix_data_o SHALL be pixel slice [idx*PIXEL_WIDTH +: PIXEL_WIDTH] of the FIFO head word, where idx is the pixel index; the least-significant pixel is output first.
REQ-026 On pix_valid_o && pix_ready_i, idx SHALL increment; when idx reaches PPW-1 it SHALL wrap to 0 and the FIFO head SHALL be popped.
REQ-027 A FIFO push and a pop in the same cycle SHALL both take effect, leaving the count unchanged.
REQ-028 pix_last_o SHALL be 1 only for the pixel at idx = PPW-1 of word FRAME_WORDS-1.
REQ-029 When the pix_last_o pixel is accepted, DRAIN SHALL move to IDLE.
REQ-030 pix_data_o and pix_last_o SHALL hold stable while pix_valid_o && !pix_ready_i.
REQ-031 underrun_o SHALL be set in any cycle where the state is RUN, pix_ready_i = 1 and pix_valid_o = 0; it SHALL stay set until start_i or reset.
REQ-032 Minimum latency from start_i to the first pix_valid_o SHALL be 3 cycles: start registered, read issued, data pushed.
REQ-033 Once the FIFO is primed and pix_ready_i is held at 1, the block SHALL sustain one pixel per cycle.

Reset
REQ-034 While rstn_i = 0, the block SHALL be in IDLE with the following values: ram_en_o = 0, ram_addr_o = 0, word address = 0, idx = 0, FIFO empty, in-flight = 0, pix_valid_o = 0, pix_data_o = 0, pix_last_o = 0, underrun_o = 0.
REQ-035 After rstn_i deasserts, the block SHALL stay in IDLE until start_i.
REQ-036 A read data beat that returns in the first cycle after reset SHALL be ignored.

Structure
REQ-037 A shared package vga_pkg SHALL hold the FSM state enum fb_rd_state_t and the default-width constants (PIXEL_WIDTH, RAM_WIDTH).
REQ-038 The prefetch FIFO SHALL be a sub-module, sync_fifo, with a synchronous flush input, a same-cycle push/pop rule, and count, full and empty outputs.
REQ-039 fb_reader SHALL connect to one port of xilinx_true_dual_port_read_first_1_clock_ram with no glue logic.

Verification
REQ-040 Scenario: FRAME_WORDS = 4, PPW = 2, BRAM words 0x00B00A..0x00B00D (hex, 24-bit), start_i, pix_ready_i = 1 -> pixels 0x00A, 0x00B, 0x00B, 0x00B, ... in low-then-high order, 8 pixels, pix_last_o high on the 8th, then IDLE, underrun_o = 0.
REQ-041 Scenario: pix_ready_i = 0 after start_i -> exactly FIFO_DEPTH reads issued, then ram_en_o = 0; pix_data_o stable; releasing ready resumes reads with no gap and no duplicate.
REQ-042 Scenario: pix_ready_i toggled randomly at 50% over 3 frames against a golden model -> the pixel sequence matches exactly and pix_last_o is seen once per frame.
REQ-043 Scenario: start_i mid-frame at word 5, with a read in flight -> the next pixel out is word 0 pixel 0; no stale data appears and underrun_o is cleared.
REQ-044 Scenario: rstn_i asserted mid-RUN -> all outputs take reset values within the same cycle, asynchronously, and no ram_en_o until the next start_i.
REQ-045 Scenario: pix_ready_i = 1 in the cycle straight after start_i -> underrun_o = 1 and stays set through the frame end; the next start_i clears it.
